// File: rtl/dat_transfer_sequencer.sv
// dat_transfer_sequencer: issues DAT transfers to the PHY, retrying after
// data timeouts with a recovery gap and honouring host aborts.
module dat_transfer_sequencer #(
  parameter int MAX_RETRY      = 2,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_multiple,
  input  logic [3:0]  req_blocks,
  input  logic [15:0] req_timeout,
  input  logic        host_abort,
  output logic        phy_strobe,
  output logic        phy_ack,
  output logic        phy_idle,
  output logic        phy_write_read,
  output logic        phy_multiple,
  output logic [3:0]  phy_blocks,
  output logic [15:0] phy_timeout,
  input  logic        phy_serial_ready,
  input  logic        phy_complete,
  input  logic        phy_ack_out,
  input  logic        phy_data_timeout,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_abort,
  output logic [1:0]  retry_cnt
);
  typedef enum logic [2:0] {IDLE, ISSUE, ACTIVE, ACK, ABORT, RECOVER, DONE} state_t;
  localparam logic [1:0] MAX_R    = 2'(MAX_RETRY);
  localparam logic [3:0] REC_LAST = 4'(RECOVER_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] rec_cnt, rec_cnt_n, phy_blocks_n;
  logic [15:0] phy_timeout_n;
  logic [1:0] retry_cnt_n;
  logic accept, abort_hit, retry_ok;
  logic req_ready_n, phy_strobe_n, phy_ack_n, phy_idle_n, phy_write_read_n, phy_multiple_n;
  logic busy_n, done_n, err_timeout_n, err_abort_n;
  assign accept    = state == IDLE && req_valid;
  assign abort_hit = host_abort && state != IDLE && state != DONE;
  assign retry_ok  = retry_cnt < MAX_R;
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      phy_strobe     <= 1'b0;
      phy_ack        <= 1'b0;
      phy_idle       <= 1'b0;
      phy_write_read <= 1'b0;
      phy_multiple   <= 1'b0;
      phy_blocks     <= '0;
      phy_timeout    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      err_abort      <= 1'b0;
      retry_cnt      <= '0;
      rec_cnt        <= '0;
    end else begin
      state          <= state_n;
      req_ready      <= req_ready_n;
      phy_strobe     <= phy_strobe_n;
      phy_ack        <= phy_ack_n;
      phy_idle       <= phy_idle_n;
      phy_write_read <= phy_write_read_n;
      phy_multiple   <= phy_multiple_n;
      phy_blocks     <= phy_blocks_n;
      phy_timeout    <= phy_timeout_n;
      busy           <= busy_n;
      done           <= done_n;
      err_timeout    <= err_timeout_n;
      err_abort      <= err_abort_n;
      retry_cnt      <= retry_cnt_n;
      rec_cnt        <= rec_cnt_n;
    end
  end
  // An abort seen while already aborting just finishes the transfer, so a held host_abort cannot loop
  always_comb begin
    state_n = state;
    if (abort_hit) state_n = state == ABORT ? DONE : ABORT;
    else
      case (state)
        IDLE:    state_n = req_valid ? ISSUE : IDLE;
        ISSUE:   state_n = phy_serial_ready ? ACTIVE : ISSUE;
        ACTIVE:  state_n = phy_complete ? ACK : phy_data_timeout ? ABORT : ACTIVE;
        ACK:     state_n = phy_ack_out ? DONE : ACK;
        ABORT:   state_n = (err_abort || !retry_ok) ? DONE : RECOVER;
        RECOVER: state_n = rec_cnt == REC_LAST ? ISSUE : RECOVER;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_comb begin
    req_ready_n      = state_n == IDLE;
    busy_n           = state_n != IDLE;
    phy_strobe_n     = state == ISSUE && state_n == ACTIVE;
    phy_ack_n        = state_n == ACK;
    phy_idle_n       = state_n == ABORT;
    done_n           = state_n == DONE;
    phy_write_read_n = accept ? req_write : phy_write_read;
    phy_multiple_n   = accept ? req_multiple : phy_multiple;
    phy_blocks_n     = accept ? ((req_multiple && req_blocks != 4'd0) ? req_blocks : 4'd1) : phy_blocks;
    phy_timeout_n    = accept ? req_timeout : phy_timeout;
    err_abort_n      = accept ? 1'b0 : err_abort | abort_hit;
    err_timeout_n    = accept ? 1'b0 : err_timeout | (state == ABORT && !abort_hit && !err_abort && !retry_ok);
    retry_cnt_n      = accept ? 2'd0
                     : (state == ABORT && state_n == RECOVER && retry_cnt != 2'd3) ? retry_cnt + 2'd1
                     : retry_cnt;
    rec_cnt_n        = (state == RECOVER && state_n == RECOVER) ? rec_cnt + 4'd1 : 4'd0;
  end
endmodule

// File: tb/tb_dat_transfer_sequencer.sv
// tb_dat_transfer_sequencer: directed checks of issue, retry, abort and reset
// behaviour with hand-computed expectations.
module tb_dat_transfer_sequencer;
  logic sd_clock = 1'b0, reset = 1'b1;
  logic req_valid = 0, req_write = 0, req_multiple = 0, host_abort = 0;
  logic [3:0] req_blocks = 0;
  logic [15:0] req_timeout = 0;
  logic phy_serial_ready = 1, phy_complete = 0, phy_ack_out = 0, phy_data_timeout = 0;
  logic req_ready, phy_strobe, phy_ack, phy_idle, phy_write_read, phy_multiple;
  logic [3:0] phy_blocks;
  logic [15:0] phy_timeout;
  logic busy, done, err_timeout, err_abort;
  logic [1:0] retry_cnt;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, strobes = 0, idles = 0, dones = 0, last_strobe = 0, last_idle = 0;
  int s0, i0, d0;

  dat_transfer_sequencer dut (
    .sd_clock(sd_clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_multiple(req_multiple), .req_blocks(req_blocks),
    .req_timeout(req_timeout), .host_abort(host_abort), .phy_strobe(phy_strobe),
    .phy_ack(phy_ack), .phy_idle(phy_idle), .phy_write_read(phy_write_read),
    .phy_multiple(phy_multiple), .phy_blocks(phy_blocks), .phy_timeout(phy_timeout),
    .phy_serial_ready(phy_serial_ready), .phy_complete(phy_complete),
    .phy_ack_out(phy_ack_out), .phy_data_timeout(phy_data_timeout), .busy(busy),
    .done(done), .err_timeout(err_timeout), .err_abort(err_abort), .retry_cnt(retry_cnt)
  );

  always #5 sd_clock = ~sd_clock;

  always @(negedge sd_clock) begin
    cyc++;
    if (phy_strobe) begin strobes++; last_strobe = cyc; end
    if (phy_idle) begin idles++; last_idle = cyc; end
    if (done) dones++;
  end

  task automatic tick();
    @(posedge sd_clock);
    @(negedge sd_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!phy_strobe && n < 20) begin tick(); n++; end
    check(tag, {31'b0, phy_strobe}, 1);
  endtask

  task automatic request(input logic w, input logic m, input logic [3:0] b, input logic [15:0] t);
    req_valid = 1; req_write = w; req_multiple = m; req_blocks = b; req_timeout = t;
    tick();
    req_valid = 0;
  endtask

  task automatic finish_ok(input string tag);
    wait_strobe(tag);
    phy_complete = 1; tick(); phy_complete = 0;
    phy_ack_out = 1; tick(); phy_ack_out = 0;
    tick();
  endtask

  initial begin
    tick(); tick();
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_outs", {busy, done, phy_strobe, phy_ack, phy_idle, err_timeout, err_abort, retry_cnt, phy_blocks}, 0);
    check("rst_timeout", {16'b0, phy_timeout}, 0);
    reset = 0;
    tick();
    host_abort = 1; tick(); host_abort = 0;
    check("idle_abort_ignored", {req_ready, busy, err_abort, phy_idle}, 4'b1000);

    // single write
    request(1, 0, 4'd1, 16'h1234);
    check("wr_accept", {req_ready, busy, phy_write_read, phy_multiple, phy_blocks}, {4'b0110, 4'd1});
    check("wr_timeout", {16'b0, phy_timeout}, 32'h1234);
    tick();
    check("wr_strobe", {31'b0, phy_strobe}, 1);
    tick();
    check("wr_strobe_once", {31'b0, phy_strobe}, 0);
    repeat (19) tick();
    phy_complete = 1; tick(); phy_complete = 0;
    check("wr_ack", {31'b0, phy_ack}, 1);
    repeat (3) tick();
    check("wr_ack_held", {phy_ack, done}, 2'b10);
    phy_ack_out = 1; tick(); phy_ack_out = 0;
    check("wr_done", {done, phy_ack}, 2'b10);
    tick();
    check("wr_idle", {done, req_ready, busy, err_timeout, err_abort, retry_cnt}, 7'b0100000);

    // multi read, then zero-block multi read
    request(0, 1, 4'd5, 16'h0040);
    check("mr_params", {phy_write_read, phy_multiple, phy_blocks}, {2'b01, 4'd5});
    req_valid = 1; req_blocks = 4'd9; req_write = 1; tick(); req_valid = 0;
    check("mr_ignore_busy", {phy_write_read, phy_blocks}, {1'b0, 4'd5});
    finish_ok("mr_strobe");
    request(0, 1, 4'd0, 16'h0040);
    check("mr_zero_blocks", {28'b0, phy_blocks}, 1);
    finish_ok("mr0_strobe");
    request(1, 0, 4'd7, 16'h0040);
    check("single_forced_1", {28'b0, phy_blocks}, 1);
    finish_ok("s1_strobe");

    // two timeouts then success
    s0 = strobes; i0 = idles;
    request(1, 1, 4'd3, 16'h0100);
    for (int k = 0; k < 2; k++) begin
      wait_strobe("rt_strobe");
      phy_data_timeout = 1; tick(); phy_data_timeout = 0;
      check("rt_idle_pulse", {31'b0, phy_idle}, 1);
      tick();
      check("rt_idle_once", {phy_idle, phy_strobe, busy}, 3'b001);
      wait_strobe("rt_restrobe");
      check("rt_gap", last_strobe - last_idle, 6);
    end
    phy_complete = 1; tick(); phy_complete = 0;
    phy_ack_out = 1; tick(); phy_ack_out = 0;
    check("rt_done", {done, err_timeout, err_abort, retry_cnt}, {3'b100, 2'd2});
    check("rt_strobes", strobes - s0, 3);
    check("rt_idles", idles - i0, 2);
    check("rt_params_kept", {phy_multiple, phy_blocks}, {1'b1, 4'd3});
    tick();

    // exhaustion
    s0 = strobes; i0 = idles;
    request(0, 0, 4'd1, 16'h0010);
    for (int k = 0; k < 3; k++) begin
      wait_strobe("ex_strobe");
      phy_data_timeout = 1; tick(); phy_data_timeout = 0;
      tick();
    end
    check("ex_done", {done, err_timeout, err_abort, retry_cnt}, {3'b110, 2'd2});
    check("ex_strobes", strobes - s0, 3);
    check("ex_idles", idles - i0, 3);
    tick();
    check("ex_hold", {req_ready, done, err_timeout, retry_cnt}, {3'b101, 2'd2});

    // host abort in ACK
    request(1, 0, 4'd1, 16'h0010);
    check("new_req_clears", {err_timeout, err_abort, retry_cnt}, 0);
    wait_strobe("ab_strobe");
    phy_complete = 1; tick(); phy_complete = 0;
    check("ab_in_ack", {31'b0, phy_ack}, 1);
    host_abort = 1; tick(); host_abort = 0;
    check("ab_abort", {phy_idle, err_abort, phy_ack}, 3'b110);
    tick();
    check("ab_done", {done, phy_idle, err_abort, err_timeout, retry_cnt}, 6'b101000);
    tick();
    check("ab_idle", {31'b0, req_ready}, 1);

    // complete and timeout together
    request(0, 0, 4'd1, 16'h0010);
    wait_strobe("both_strobe");
    phy_complete = 1; phy_data_timeout = 1; tick(); phy_complete = 0; phy_data_timeout = 0;
    check("both_ack", {phy_ack, phy_idle}, 2'b10);
    phy_ack_out = 1; tick(); phy_ack_out = 0;
    check("both_done", {done, err_timeout, retry_cnt}, 4'b1000);
    tick();

    // reset during RECOVER
    request(1, 1, 4'd4, 16'hBEEF);
    wait_strobe("rs_strobe");
    phy_data_timeout = 1; tick(); phy_data_timeout = 0;
    tick();
    check("rs_in_recover", {busy, phy_idle, retry_cnt}, {2'b10, 2'd1});
    d0 = dones; i0 = idles;
    reset = 1; tick();
    check("rs_ready", {31'b0, req_ready}, 1);
    check("rs_outs", {busy, done, phy_strobe, phy_ack, phy_idle, phy_write_read, phy_multiple,
                      err_timeout, err_abort, retry_cnt, phy_blocks}, 0);
    check("rs_timeout", {16'b0, phy_timeout}, 0);
    reset = 0; tick(); tick();
    check("rs_no_pulses", (dones - d0) + (idles - i0), 0);
    check("rs_still_idle", {req_ready, busy}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dat_transfer_sequencer.md
DAT_TRANSFER_SEQUENCER -- requirements
Module: dat_transfer_sequencer

Interface
REQ-001 Parameter MAX_RETRY, default 2, meaning: number of re-issues allowed after a DAT timeout; legal range 0..3.
REQ-002 Parameter RECOVER_CYCLES, default 4, meaning: idle gap in cycles between an abort and a re-issue; legal range 1..15.
REQ-003 Clock and reset SHALL be: sd_clock; reset is synchronous and active-high.
REQ-004 Host ports SHALL be:
- sd_clock  in  1  clock
- reset  in  1  sync active-high reset
- req_valid  in  1  transfer request
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1=write, 0=read
- req_multiple  in  1  multi-block transfer
- req_blocks  in  4  block count
- req_timeout  in  16  DAT timeout value
- host_abort  in  1  cancel transfer
REQ-005 PHY-side ports SHALL be:
- phy_strobe  out  1  start pulse
- phy_ack  out  1  host ack
- phy_idle  out  1  force PHY to IDLE
- phy_write_read  out  1  direction
- phy_multiple  out  1  multi-block
- phy_blocks  out  4  block count
- phy_timeout  out  16  timeout value
- phy_serial_ready  in  1  PHY ready
- phy_complete  in  1  PHY done
- phy_ack_out  in  1  PHY ack
- phy_data_timeout  in  1  PHY timeout flag
REQ-006 Status ports SHALL be:
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err_timeout  out  1  retries exhausted
- err_abort  out  1  host abort
- retry_cnt  out  2  retries used

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, ACTIVE, ACK, ABORT, RECOVER, DONE; all outputs are registered.
REQ-008 IDLE: req_ready=1; on req_valid, capture req_write, req_multiple, req_blocks, req_timeout into the phy_* registers, clear retry_cnt and both error flags, go to ISSUE the next cycle.
REQ-009 req_blocks==0 SHALL be captured as 1; when req_multiple=0, phy_blocks SHALL be 1 regardless of req_blocks.
REQ-010 ISSUE: wait for phy_serial_ready=1, then assert phy_strobe for exactly one cycle, then go to ACTIVE; phy_strobe is 0 in every other state.
REQ-011 ACTIVE: on phy_complete=1 go to ACK; else on phy_data_timeout=1 go to ABORT; when both are high in the same cycle, phy_complete wins.
REQ-012 ACK: hold phy_ack=1 until phy_ack_out=1, then deassert and go to DONE.
REQ-013 ABORT: assert phy_idle=1 for one cycle.
- If retry_cnt<MAX_RETRY: increment retry_cnt, go to RECOVER.
- Else: set err_timeout=1, go to DONE.
REQ-014 RECOVER: count RECOVER_CYCLES cycles with all PHY strobes low, then go to ISSUE with the same captured parameters.
REQ-015 host_abort=1 in any state other than IDLE or DONE SHALL set err_abort=1 and go to ABORT with no retry; this takes priority over all other transitions; host_abort in IDLE is ignored.
REQ-016 DONE: done=1 for one cycle, then go to IDLE; err_* and retry_cnt hold their values until the next accepted request.
REQ-017 retry_cnt SHALL saturate at 3 and never wrap.
REQ-018 req_valid is ignored while busy=1; captured parameters stay constant from the accept cycle until return to IDLE.

Reset
REQ-019 Reset SHALL force state IDLE, req_ready=1, and every other output 0, including phy_* registers, retry_cnt and the RECOVER counter.
REQ-020 Reset asserted mid-transfer SHALL take effect the next edge with no done pulse and no phy_idle pulse.

Verification
REQ-021 Single write: req_valid, write=1, blocks=1, serial_ready=1 -> strobe one cycle; complete after 20 cycles -> ack held until ack_out -> done pulse; err_*=0, retry_cnt=0.
REQ-022 Multi read: multiple=1, blocks=5 -> phy_blocks=5, phy_write_read=0; blocks=0 with multiple=1 -> phy_blocks=1.
REQ-023 Timeout retry: data_timeout in ACTIVE twice with MAX_RETRY=2 -> 2 phy_idle pulses, 4-cycle gaps, 3 strobes total; third attempt completes -> retry_cnt=2, err_timeout=0.
REQ-024 Exhaustion: data_timeout on every attempt -> 3 strobes, then err_timeout=1 and done pulse; retry_cnt=2.
REQ-025 host_abort in ACK -> phy_idle pulse, err_abort=1, no retry, done pulse; a simultaneous complete and data_timeout in ACTIVE -> goes to ACK.
REQ-026 Reset asserted in RECOVER -> next cycle IDLE, req_ready=1, all other outputs 0, no done pulse.
